hash_table_arbiter: RTL

HASH_TABLE_ARBITER -- requirements
Module: hash_table_arbiter

---
 rtl/hash_table_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hash_table_arbiter.sv
// hash_table_arbiter: round-robin arbiter that serialises NUM_REQ requesters onto one
// hash table port. One transaction at a time: IDLE grants, BUSY drives the table, RESP
// turns the result into a one-cycle resp_valid pulse for the granted requester.
// Optional watchdog on BUSY is compiled in with `define HASH_ARB_TIMEOUT_EN.

module hash_table_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned KEY_WIDTH      = 32,
    parameter int unsigned VALUE_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [2*NUM_REQ-1:0]           req_op_sel,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [VALUE_WIDTH-1:0]         resp_value,
    output logic                           resp_error,
    output logic                           resp_timeout,
    output logic [KEY_WIDTH-1:0]           ht_key_in,
    output logic [VALUE_WIDTH-1:0]         ht_value_in,
    output logic [1:0]                     ht_op_sel,
    output logic                           ht_op_en,
    input  logic [VALUE_WIDTH-1:0]         ht_value_out,
    input  logic                           ht_op_done,
    input  logic                           ht_op_error,
    output logic                           busy,
    output logic [ID_WIDTH-1:0]            grant_id
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [NUM_REQ-1:0] ONE_HOT_BASE = NUM_REQ'(1);
    localparam logic [1:0]         OP_INVALID   = 2'b11;

    state_e                 state;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic                   grant_found;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [31:0]            cand_sum;
    logic [ID_WIDTH-1:0]    cand;
    logic [1:0]             sel_op;
    logic [KEY_WIDTH-1:0]   sel_key;
    logic [VALUE_WIDTH-1:0] sel_value;
    logic [ID_WIDTH-1:0]    next_ptr;

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] busy_cnt;
    logic                 timeout_flag;
    logic                 timeout_hit;

    // busy_cnt == n means n BUSY edges have already passed without completion
    assign timeout_hit  = (busy_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign resp_timeout = timeout_flag;
`else
    assign resp_timeout = 1'b0;
`endif

    // Round-robin search: first valid requester at or after rr_ptr, wrapping to 0
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_sum = 32'(rr_ptr) + i;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand = cand_sum[ID_WIDTH-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_op    = req_op_sel[2*grant_idx +: 2];
    assign sel_key   = req_key[32'(grant_idx)*KEY_WIDTH +: KEY_WIDTH];
    assign sel_value = req_value[32'(grant_idx)*VALUE_WIDTH +: VALUE_WIDTH];
    assign next_ptr  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            rr_ptr       <= '0;
            grant_id     <= '0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_value   <= '0;
            resp_error   <= 1'b0;
            ht_key_in    <= '0;
            ht_value_in  <= '0;
            ht_op_sel    <= '0;
            ht_op_en     <= 1'b0;
            busy         <= 1'b0;
`ifdef HASH_ARB_TIMEOUT_EN
            busy_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            unique case (state)
                StIdle: begin
                    if (grant_found) begin
                        req_ready   <= ONE_HOT_BASE << grant_idx;
                        grant_id    <= grant_idx;
                        ht_op_sel   <= sel_op;
                        ht_key_in   <= sel_key;
                        ht_value_in <= sel_value;
                        // An invalid op never reaches the table
                        ht_op_en    <= (sel_op != OP_INVALID);
                        busy        <= 1'b1;
                        state       <= StBusy;
`ifdef HASH_ARB_TIMEOUT_EN
                        busy_cnt    <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (ht_op_sel == OP_INVALID) begin
                        resp_error   <= 1'b1;
`ifdef HASH_ARB_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                        state        <= StResp;
                    end else if (ht_op_done) begin
                        // Completion wins over a coincident watchdog expiry
                        resp_value   <= ht_value_out;
                        resp_error   <= ht_op_error;
                        ht_op_en     <= 1'b0;
`ifdef HASH_ARB_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                        state        <= StResp;
                    end
`ifdef HASH_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        resp_error   <= 1'b1;
                        timeout_flag <= 1'b1;
                        ht_op_en     <= 1'b0;
                        state        <= StResp;
                    end else begin
                        busy_cnt     <= busy_cnt + 1'b1;
                    end
`endif
                end
                StResp: begin
                    resp_valid <= ONE_HOT_BASE << grant_id;
                    rr_ptr     <= next_ptr;
                    ht_op_en   <= 1'b0;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    ht_op_en <= 1'b0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule
